// File: rtl/sync_counter_updown_n.sv
// rtl/sync_counter_updown_n.sv - parametrised up/down counter with prescaler, wrap/saturate, tc pulse and sticky overflow
module sync_counter_updown_n #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               PRESCALE = 1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             l,
    input  logic             s_s,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] c,
    output logic             tc,
    output logic             ovf
);

    // Prescaler needs at least one bit even when PRESCALE=1 (it then never leaves 0).
    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   PRE_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] r_c;
    logic             r_tc;
    logic             r_ovf;
    logic [PW-1:0]    r_pre;

    logic             w_step_due;
    logic             w_at_term;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;

    // Decode step timing, terminal detection, clamped load value and next count on a step.
    always_comb begin
        w_step_due = s_s && (r_pre == PRE_LAST);
        w_at_term  = dir ? (r_c == MAX_VAL) : (r_c == ZERO);
        w_load_val = (d > MAX_VAL) ? MAX_VAL : d;
        w_step_val = r_c;
        if (w_at_term) begin
            // Terminal step: wrap to the opposite end, or hold when saturating.
            if (!SATURATE) begin
                w_step_val = dir ? ZERO : MAX_VAL;
            end
        end else begin
            w_step_val = dir ? (r_c + ONE) : (r_c - ONE);
        end
    end

    // Counter state: clr beats load, load beats step, step beats hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_c   <= ZERO;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
            r_pre <= '0;
        end else if (l) begin
            r_c   <= w_load_val;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
            r_pre <= '0;
        end else if (w_step_due) begin
            r_pre <= '0;
            r_c   <= w_step_val;
            r_tc  <= w_at_term;
            if (w_at_term) begin
                r_ovf <= 1'b1;
            end
        end else if (s_s) begin
            // Running but mid-prescale: advance phase only.
            r_pre <= r_pre + PRE_ONE;
            r_tc  <= 1'b0;
        end else begin
            // Stopped: count and prescaler phase freeze.
            r_tc  <= 1'b0;
        end
    end

    assign c   = r_c;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule
